pool_frame_assembler: RTL and testbench
=======================================

Name: pool_frame_assembler

Overview:
- Streaming-to-parallel frame collector that sits directly upstream of the combinational max-pooling stage.
- Accepts one feature-map element per cycle from the convolution/activation stage over a valid/ready handshake.
- Assembles the full flattened CHANNEL x DATAHEIGHT x DATAWIDTH frame in a register bank and presents it as one wide, stable vector to the pooling input until the consumer accepts it.

Parameters:
- BITWIDTH, 16, bits per element (two's-complement, passed through untouched)
- DATAWIDTH, 28, elements per row
- DATAHEIGHT, 28, rows per channel
- CHANNEL, 1, channels per frame
- Derived (localparam): N = CHANNEL*DATAHEIGHT*DATAWIDTH; CW = $clog2(N)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  upstream element valid
- in_ready  output  1  block can accept an element
- in_data  input  BITWIDTH  element value
- in_last  input  1  upstream marks final element of frame
- frame_valid  output  1  frame_data holds a complete frame
- frame_ready  input  1  downstream accepts frame
- frame_data  output  BITWIDTH*N  flattened frame, pooling input layout
- frame_err  output  1  one-cycle pulse on framing error

Behaviour:
- Interface: one clock clk; reset rst_n is asynchronous, active-low.
- Reset values: in_ready=0 during reset, 1 on first cycle after release; frame_valid=0; frame_err=0; index counter=0; frame_data bank=0.
- States:
  - FILL: in_ready=1, frame_valid=0.
  - HOLD: in_ready=0, frame_valid=1.
- Accept: an element is taken on a rising edge with in_valid & in_ready. It is written to element index i = idx counter, bits [i*BITWIDTH +: BITWIDTH].
- Ordering: col fastest, then row, then channel: i = ch*DATAHEIGHT*DATAWIDTH + row*DATAWIDTH + col.
- Counter: increments by 1 per accept and wraps to 0 after index N-1.
- FILL->HOLD: on accepting index N-1. frame_valid rises the next cycle (latency 1 cycle from last accept).
- HOLD: frame_data must not change. in_valid is ignored (no accept) and in_data is don't-care.
- HOLD->FILL: on frame_valid & frame_ready. in_ready=1 the next cycle. The bank is not cleared; a new frame overwrites it.
- Framing, early in_last: in_last=1 on an accept with i<N-1 aborts the frame. Counter->0, stay in FILL, frame_err pulses next cycle, no frame emitted.
- Framing, missing in_last: in_last=0 on the accept of i=N-1 still completes the frame (HOLD), and frame_err pulses next cycle.
- Reset mid-frame or in HOLD: all state returns to reset values immediately and the partial or held frame is discarded.
- frame_ready while frame_valid=0 has no effect.
- No combinational path from in_valid to in_ready or from frame_ready to frame_valid; all outputs are registered.

Decomposition:
- Shared package (pool_pkg): LeNet layer dimension constants (28x28x1, 14x14 etc.), N/element-index helper function, state enum {FILL, HOLD}.
- No sub-module needed: single module containing state FSM, index counter, write-decode into the register bank.

Test Plan (bench params W=4,H=4,C=1, N=16):
- Reset, then stream values 0..15 with in_last on 15 and frame_ready=0 -> frame_valid=1 exactly 1 cycle after the 16th accept. Element i equals i; in_ready=0 while held; frame_err never pulses.
- Hold frame 5 cycles while driving in_valid=1, in_data=16'hFFFF -> frame_data unchanged. Then frame_ready=1 for one cycle -> frame_valid=0 and in_ready=1 on the next cycle.
- Random in_valid gaps (~50%) with values 16'h8000+i -> frame identical to the gap-free case; signed extremes (16'h8000, 16'h7FFF) preserved bit-exactly.
- in_last asserted on the element at i=7 -> frame_err pulse 1 cycle, no frame_valid. The next 16 elements (in_last on the 16th) form a clean frame starting at index 0.
- 16 elements with in_last never asserted -> frame emitted normally plus a single frame_err pulse 1 cycle after the last accept.
- Assert rst_n=0 after 9 accepts, release, send a full frame of 16'h00AA -> all 16 elements equal 16'h00AA, no stale data from the aborted frame.

Source files
------------

// File: rtl/pool_frame_assembler_pkg.sv
// Shared constants, state encoding and index helpers for the pooling frame assembler.
package pool_frame_assembler_pkg;

    // LeNet layer dimensions feeding the pooling stages
    localparam int unsigned LENET_C1_W = 28;
    localparam int unsigned LENET_C1_H = 28;
    localparam int unsigned LENET_C1_C = 1;
    localparam int unsigned LENET_P1_W = 14;
    localparam int unsigned LENET_P1_H = 14;
    localparam int unsigned LENET_C3_W = 10;
    localparam int unsigned LENET_C3_H = 10;
    localparam int unsigned LENET_P2_W = 5;
    localparam int unsigned LENET_P2_H = 5;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

    function automatic int unsigned frame_elems(input int unsigned ch,
                                                input int unsigned h,
                                                input int unsigned w);
        return ch * h * w;
    endfunction

    // Flattened position: column fastest, then row, then channel
    function automatic int unsigned elem_index(input int unsigned ch,
                                               input int unsigned row,
                                               input int unsigned col,
                                               input int unsigned h,
                                               input int unsigned w);
        return (ch * h * w) + (row * w) + col;
    endfunction

endpackage

// File: rtl/pool_frame_assembler.sv
// Collects a streamed CHANNEL x HEIGHT x WIDTH frame into a register bank and
// presents it as one stable wide vector until the pooling stage accepts it.
module pool_frame_assembler
    import pool_frame_assembler_pkg::*;
#(
    parameter int unsigned BITWIDTH   = 16,
    parameter int unsigned DATAWIDTH  = 28,
    parameter int unsigned DATAHEIGHT = 28,
    parameter int unsigned CHANNEL    = 1
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    in_valid,
    output logic                                    in_ready,
    input  logic [BITWIDTH-1:0]                     in_data,
    input  logic                                    in_last,
    output logic                                    frame_valid,
    input  logic                                    frame_ready,
    output logic [BITWIDTH*CHANNEL*DATAHEIGHT*DATAWIDTH-1:0] frame_data,
    output logic                                    frame_err
);

    localparam int unsigned N  = frame_elems(CHANNEL, DATAHEIGHT, DATAWIDTH);
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

    state_e                         r_state;
    state_e                         w_state_next;
    logic [CW-1:0]                  r_idx;
    logic [CW-1:0]                  w_idx_next;
    logic                           w_accept;
    logic                           w_err;
    logic                           r_in_ready;
    logic                           r_frame_valid;
    logic                           r_frame_err;
    logic [N-1:0][BITWIDTH-1:0]     r_bank;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_FILL;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state, index advance and framing-error detection
    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        w_accept     = 1'b0;
        w_err        = 1'b0;
        case (r_state)
            ST_FILL: begin
                // r_in_ready is low in the first cycle after reset, gating accepts
                w_accept = in_valid && r_in_ready;
                if (w_accept) begin
                    if (r_idx == LAST_IDX) begin
                        w_state_next = ST_HOLD;
                        w_idx_next   = '0;
                        w_err        = !in_last;
                    end else if (in_last) begin
                        w_idx_next = '0;
                        w_err      = 1'b1;
                    end else begin
                        w_idx_next = r_idx + CW'(1);
                    end
                end
            end
            ST_HOLD: begin
                if (r_frame_valid && frame_ready) begin
                    w_state_next = ST_FILL;
                end
            end
            default: begin
                w_state_next = ST_FILL;
            end
        endcase
    end

    // Registered handshake outputs track the upcoming state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx         <= '0;
            r_in_ready    <= 1'b0;
            r_frame_valid <= 1'b0;
            r_frame_err   <= 1'b0;
        end else begin
            r_idx         <= w_idx_next;
            r_in_ready    <= (w_state_next == ST_FILL);
            r_frame_valid <= (w_state_next == ST_HOLD);
            r_frame_err   <= w_err;
        end
    end

    // Element bank; only written in FILL, so the held frame stays stable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bank <= '0;
        end else if (w_accept) begin
            r_bank[r_idx] <= in_data;
        end
    end

    assign in_ready    = r_in_ready;
    assign frame_valid = r_frame_valid;
    assign frame_err   = r_frame_err;
    assign frame_data  = r_bank;

endmodule

// File: tb/tb_pool_frame_assembler.sv
// Randomized self-checking bench for pool_frame_assembler against a
// transaction-level frame model (4x4x1 frame, 16-bit elements).
module tb_pool_frame_assembler;

    localparam int unsigned BW = 16;
    localparam int unsigned W  = 4;
    localparam int unsigned H  = 4;
    localparam int unsigned C  = 1;
    localparam int unsigned N  = C * H * W;
    localparam int unsigned FW = BW * N;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [BW-1:0] in_data;
    logic          in_last;
    logic          frame_valid;
    logic          frame_ready;
    logic [FW-1:0] frame_data;
    logic          frame_err;

    pool_frame_assembler #(
        .BITWIDTH  (BW),
        .DATAWIDTH (W),
        .DATAHEIGHT(H),
        .CHANNEL   (C)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .frame_valid(frame_valid),
        .frame_ready(frame_ready),
        .frame_data (frame_data),
        .frame_err  (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Frame model: collected elements, write position, and expected handshake view
    logic [BW-1:0] m_bank [N];
    int            m_idx;
    bit            m_hold;
    bit            m_ready;
    bit            m_valid;
    bit            m_err;
    bit            m_acc;

    task automatic chk(input string tag, input logic [FW-1:0] got, input logic [FW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [FW-1:0] m_frame();
        logic [FW-1:0] v;
        for (int i = 0; i < N; i++) v[i*BW +: BW] = m_bank[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_bank[i] = '0;
        m_idx   = 0;
        m_hold  = 1'b0;
        m_ready = 1'b0;
        m_valid = 1'b0;
        m_err   = 1'b0;
        m_acc   = 1'b0;
    endtask

    task automatic check_outputs();
        chk("in_ready",    FW'(in_ready),    FW'(m_ready));
        chk("frame_valid", FW'(frame_valid), FW'(m_valid));
        chk("frame_err",   FW'(frame_err),   FW'(m_err));
        chk("frame_data",  frame_data,       m_frame());
    endtask

    // One clock: check settled outputs, drive inputs, advance the model at the edge
    task automatic step(input bit v, input logic [BW-1:0] d, input bit l, input bit fr);
        bit take;
        check_outputs();
        in_valid    = v;
        in_data     = d;
        in_last     = l;
        frame_ready = fr;
        @(posedge clk);
        m_acc = v && m_ready;
        take  = m_valid && fr;
        m_err = 1'b0;
        if (m_acc) begin
            m_bank[m_idx] = d;
            if (m_idx == N - 1) begin
                m_hold = 1'b1;
                m_err  = !l;
                m_idx  = 0;
            end else if (l) begin
                m_idx = 0;
                m_err = 1'b1;
            end else begin
                m_idx++;
            end
        end
        if (take) m_hold = 1'b0;
        m_ready = !m_hold;
        m_valid = m_hold;
        @(negedge clk);
    endtask

    // Offer one element with random idle gaps until it is taken
    task automatic send_elem(input logic [BW-1:0] d, input bit l, input int gap_pct);
        bit v;
        for (int n = 0; n < 64; n++) begin
            v = ($urandom_range(99) >= gap_pct);
            step(v, v ? d : BW'($urandom), v ? l : 1'b0, 1'($urandom));
            if (m_acc) return;
        end
        chk("accept_timeout", FW'(m_acc), FW'(1));
    endtask

    task automatic release_frame();
        step(1'b0, '0, 1'b0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b0);
    endtask

    logic [FW-1:0] exp_v;
    logic [BW-1:0] vals [N];

    initial begin
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_data     = '0;
        in_last     = 1'b0;
        frame_ready = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_in_ready",    FW'(in_ready),    FW'(0));
        chk("rst_frame_valid", FW'(frame_valid), FW'(0));
        chk("rst_frame_err",   FW'(frame_err),   FW'(0));
        chk("rst_frame_data",  frame_data,       '0);
        rst_n = 1'b1;
        step(1'b0, '0, 1'b0, 1'b0);

        // Sequential values, no gaps, then hold under in_valid pressure
        for (int i = 0; i < N; i++) send_elem(BW'(i), i == N - 1, 0);
        for (int i = 0; i < N; i++) exp_v[i*BW +: BW] = BW'(i);
        chk("seq_frame", frame_data, exp_v);
        chk("seq_valid", FW'(frame_valid), FW'(1));
        for (int k = 0; k < 5; k++) step(1'b1, 16'hFFFF, 1'b0, 1'b0);
        chk("hold_stable", frame_data, exp_v);
        step(1'b1, 16'hFFFF, 1'b0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b0);
        chk("after_release_ready", FW'(in_ready), FW'(1));

        // Random gaps with signed extremes
        for (int i = 0; i < N; i++) vals[i] = (i == N - 1) ? 16'h7FFF : BW'(16'h8000 + i);
        for (int i = 0; i < N; i++) send_elem(vals[i], i == N - 1, 50);
        for (int i = 0; i < N; i++) exp_v[i*BW +: BW] = vals[i];
        chk("gap_frame", frame_data, exp_v);
        release_frame();

        // Early in_last at index 7, then a clean random frame from index 0
        for (int i = 0; i < 8; i++) send_elem(BW'(16'h1000 + i), i == 7, 30);
        for (int i = 0; i < N; i++) vals[i] = BW'($urandom);
        for (int i = 0; i < N; i++) send_elem(vals[i], i == N - 1, 30);
        for (int i = 0; i < N; i++) exp_v[i*BW +: BW] = vals[i];
        chk("after_abort_frame", frame_data, exp_v);
        release_frame();

        // Missing in_last still completes the frame with an error pulse
        for (int i = 0; i < N; i++) send_elem(BW'($urandom), 1'b0, 20);
        chk("nolast_valid", FW'(frame_valid), FW'(1));
        step(1'b0, '0, 1'b0, 1'b0);
        release_frame();

        // Reset mid-frame discards partial data
        for (int i = 0; i < 9; i++) send_elem(16'h5A00 + BW'(i), 1'b0, 20);
        rst_n = 1'b0;
        model_reset();
        #1;
        check_outputs();
        chk("midrst_bank", frame_data, '0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < N; i++) send_elem(16'h00AA, i == N - 1, 20);
        for (int i = 0; i < N; i++) exp_v[i*BW +: BW] = 16'h00AA;
        chk("post_rst_frame", frame_data, exp_v);
        release_frame();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
